// File: rtl/or_pkg.sv
// Shared types and default sizes for the Or block and its frame accumulator.
package or_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } or_acc_state_t;

    localparam int OR_BITWIDTH = 8;
    localparam int OR_FRAMELEN = 4;

endpackage

// File: rtl/or_frame_accumulator_or.sv
// The Or block: purely combinational bitwise OR of two words.
module or_frame_accumulator_or #(
    parameter int BitWidth = 8
) (
    input  logic [BitWidth-1:0] A,
    input  logic [BitWidth-1:0] B,
    output logic [BitWidth-1:0] C
);

    assign C = A | B;

endmodule

// File: rtl/or_frame_accumulator.sv
// ORs up to FrameLen accepted words into a sticky accumulator and presents one
// result word per frame on a valid/ready output, with a one-cycle HOLD bubble.
module or_frame_accumulator
    import or_pkg::*;
#(
    parameter  int BitWidth   = OR_BITWIDTH,
    parameter  int FrameLen   = OR_FRAMELEN,
    localparam int CountWidth = $clog2(FrameLen + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BitWidth-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BitWidth-1:0]   out_data,
    output logic [CountWidth-1:0] out_count
);

    or_acc_state_t         stateReg, stateNext;
    logic [BitWidth-1:0]   accReg, accNext;
    logic [CountWidth-1:0] countReg, countNext;
    logic                  inReadyReg, inReadyNext;
    logic                  outValidReg, outValidNext;
    logic [BitWidth-1:0]   outDataReg, outDataNext;
    logic [CountWidth-1:0] outCountReg, outCountNext;
    logic [BitWidth-1:0]   orResult;
    logic [CountWidth-1:0] countInc;
    logic                  accept, emit, lastBeat;

    or_frame_accumulator_or #(.BitWidth(BitWidth)) orInst (
        .A(accReg),
        .B(in_data),
        .C(orResult)
    );

    assign accept   = in_valid && inReadyReg;
    assign emit     = outValidReg && out_ready;
    assign countInc = countReg + CountWidth'(1);
    // Holds for the IDLE load too, since count is 0 there.
    assign lastBeat = in_last || (int'(countReg) + 1 == FrameLen);

    always_comb begin
        stateNext    = stateReg;
        accNext      = accReg;
        countNext    = countReg;
        outValidNext = outValidReg;
        outDataNext  = outDataReg;
        outCountNext = outCountReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    accNext   = in_data;
                    countNext = CountWidth'(1);
                    stateNext = lastBeat ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    accNext   = orResult;
                    countNext = countInc;
                    if (lastBeat) stateNext = HOLD;
                end
            end
            HOLD: begin
                if (emit) begin
                    stateNext    = IDLE;
                    accNext      = '0;
                    countNext    = '0;
                    outValidNext = 1'b0;
                    outDataNext  = '0;
                    outCountNext = '0;
                end
            end
            default: stateNext = IDLE;
        endcase
        // Capture the finished frame on entry to HOLD so outputs stay frozen there.
        if (stateReg != HOLD && stateNext == HOLD) begin
            outValidNext = 1'b1;
            outDataNext  = accNext;
            outCountNext = countNext;
        end
        inReadyNext = (stateNext != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            accReg      <= '0;
            countReg    <= '0;
            inReadyReg  <= 1'b0;
            outValidReg <= 1'b0;
            outDataReg  <= '0;
            outCountReg <= '0;
        end else begin
            stateReg    <= stateNext;
            accReg      <= accNext;
            countReg    <= countNext;
            inReadyReg  <= inReadyNext;
            outValidReg <= outValidNext;
            outDataReg  <= outDataNext;
            outCountReg <= outCountNext;
        end
    end

    assign in_ready  = inReadyReg;
    assign out_valid = outValidReg;
    assign out_data  = outDataReg;
    assign out_count = outCountReg;

endmodule

// File: tb/tb_or_frame_accumulator.sv
// Drives a FrameLen=4 and a FrameLen=1 accumulator with the same stimulus and
// checks both against a frame-level model of accepted beats.
module tb_or_frame_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic [1:0] inReady, outValid;
    logic [7:0] outData0, outData1;
    logic [2:0] outCount0;
    logic [0:0] outCount1;

    or_frame_accumulator #(.BitWidth(8), .FrameLen(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(inReady[0]), .in_data(in_data), .in_last(in_last),
        .out_valid(outValid[0]), .out_ready(out_ready), .out_data(outData0), .out_count(outCount0)
    );

    or_frame_accumulator #(.BitWidth(8), .FrameLen(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(inReady[1]), .in_data(in_data), .in_last(in_last),
        .out_valid(outValid[1]), .out_ready(out_ready), .out_data(outData1), .out_count(outCount1)
    );

    int checks   = 0;
    int failures = 0;

    // Model: list of beats accepted so far in the open frame, plus a pending result.
    int         frameLen [2] = '{4, 1};
    bit         pending  [2];
    bit         fresh    [2];
    int         beatCnt  [2];
    logic [7:0] beatBuf  [2][256];
    logic [7:0] expData  [2];
    int         expCount [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] frameOr(input int k, input int n);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < n; i++) r = r | beatBuf[k][i];
        return r;
    endfunction

    function automatic logic [7:0] dataOf(input int k);
        return (k == 0) ? outData0 : outData1;
    endfunction

    function automatic logic [31:0] countOf(input int k);
        return (k == 0) ? 32'(outCount0) : 32'(outCount1);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            pending[k] = 1'b0;
            fresh[k]   = 1'b1;
            beatCnt[k] = 0;
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("in_ready%0d", k), 32'(inReady[k]), 32'(!pending[k] && !fresh[k]));
            chk($sformatf("out_valid%0d", k), 32'(outValid[k]), 32'(pending[k]));
            if (pending[k]) begin
                chk($sformatf("out_data%0d", k), 32'(dataOf(k)), 32'(expData[k]));
                chk($sformatf("out_count%0d", k), countOf(k), 32'(expCount[k]));
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_in_ready%0d", tag, k), 32'(inReady[k]), 32'd0);
            chk($sformatf("%s_out_valid%0d", tag, k), 32'(outValid[k]), 32'd0);
            chk($sformatf("%s_out_data%0d", tag, k), 32'(dataOf(k)), 32'd0);
            chk($sformatf("%s_out_count%0d", tag, k), countOf(k), 32'd0);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (fresh[k]) begin
                fresh[k] = 1'b0;
            end else if (pending[k]) begin
                if (ordy) pending[k] = 1'b0;
            end else if (v) begin
                beatBuf[k][beatCnt[k]] = d;
                beatCnt[k]++;
                if (l || beatCnt[k] == frameLen[k]) begin
                    pending[k]  = 1'b1;
                    expData[k]  = frameOr(k, beatCnt[k]);
                    expCount[k] = beatCnt[k];
                    beatCnt[k]  = 0;
                end
            end
        end
        #1;
        checkAll();
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, ordy);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        modelReset();
        #12;
        checkResetOutputs("reset");
        #1 rst_n = 1'b1;
        idle(1, 1'b1);

        // Full frame with out_ready held high.
        cycle(1'b1, 8'h01, 1'b0, 1'b1);
        cycle(1'b1, 8'h02, 1'b0, 1'b1);
        cycle(1'b1, 8'h10, 1'b0, 1'b1);
        cycle(1'b1, 8'h80, 1'b0, 1'b1);
        chk("full_data", 32'(outData0), 32'h93);
        chk("full_count", 32'(outCount0), 32'd4);
        chk("full_ready", 32'(inReady[0]), 32'd0);
        idle(2, 1'b1);

        // Early terminate, then an all-zero frame to confirm the clear.
        cycle(1'b1, 8'h0F, 1'b0, 1'b1);
        cycle(1'b1, 8'hF0, 1'b1, 1'b1);
        chk("early_data", 32'(outData0), 32'hFF);
        chk("early_count", 32'(outCount0), 32'd2);
        idle(1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h00, 1'b0, 1'b1);
        chk("zero_data", 32'(outData0), 32'h00);
        chk("zero_count", 32'(outCount0), 32'd4);
        idle(1, 1'b1);

        // Backpressure: HOLD with in_valid pulses that must not be consumed.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'h55, 1'b1, 1'b0);
            chk("bp_data", 32'(outData0), 32'hAA);
        end
        idle(2, 1'b1);

        // Gapped input.
        cycle(1'b1, 8'h01, 1'b0, 1'b1);
        idle(3, 1'b1);
        cycle(1'b1, 8'h04, 1'b0, 1'b1);
        idle(1, 1'b1);
        cycle(1'b1, 8'h20, 1'b0, 1'b1);
        cycle(1'b1, 8'h40, 1'b0, 1'b1);
        chk("gap_data", 32'(outData0), 32'h65);
        chk("gap_count", 32'(outCount0), 32'd4);
        idle(2, 1'b1);

        // Asynchronous reset mid-frame, between clock edges.
        cycle(1'b1, 8'h03, 1'b0, 1'b1);
        cycle(1'b1, 8'h0C, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkResetOutputs("midrst");
        #2 rst_n = 1'b1;
        idle(1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10, 1'b0, 1'b1);
        chk("postrst_data", 32'(outData0), 32'h10);
        chk("postrst_count", 32'(outCount0), 32'd4);
        idle(1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
